// File: rtl/mips_pkg.sv
// Shared MIPS front-end types and constants for the instruction fetch path.
package mips_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [WORD_W-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [WORD_W-1:0] NOP_INSTR     = 32'h0000_0000;

  // One fetch-queue entry: the word and the PC it was fetched from
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus: instruction-memory read port, redirect request and decode handshake.
interface instruction_fetch_unit_if;
  import mips_pkg::*;

  logic [WORD_W-1:0] Address;
  logic [WORD_W-1:0] Instruction;
  logic              RedirectValid;
  logic [WORD_W-1:0] RedirectTarget;
  logic              OutValid;
  logic              OutReady;
  logic [WORD_W-1:0] OutInstruction;
  logic [WORD_W-1:0] OutPC;
  logic [WORD_W-1:0] OutPCPlus4;

  modport master (
    output Address,
    input  Instruction,
    input  RedirectValid,
    input  RedirectTarget,
    output OutValid,
    input  OutReady,
    output OutInstruction,
    output OutPC,
    output OutPCPlus4
  );

  modport slave (
    input  Address,
    output Instruction,
    output RedirectValid,
    output RedirectTarget,
    input  OutValid,
    output OutReady,
    input  OutInstruction,
    input  OutPC,
    input  OutPCPlus4
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Synchronous FIFO of {PC, instruction} entries with a single-cycle flush.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '{pc: '0, instr: NOP_INSTR};
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational instruction memory and
// queues {PC, word} pairs for decode; redirects flush the queue and reload the PC.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned       QUEUE_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  instruction_fetch_unit_if.master    bus
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [WORD_W-1:0] pc;
  fetch_entry_t      entry_c;
  fetch_entry_t      head;
  logic              push_c;
  logic              pop_c;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;

  // Redirect wins: the head in flight is discarded rather than handed to decode
  assign pop_c   = ~empty & bus.OutReady & ~bus.RedirectValid;
  assign push_c  = ~bus.RedirectValid & (~full | pop_c);
  assign entry_c = '{pc: pc, instr: bus.Instruction};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC & PC_ALIGN_MASK;
    end else if (bus.RedirectValid) begin
      pc <= bus.RedirectTarget & PC_ALIGN_MASK;
    end else if (push_c) begin
      pc <= pc_inc(pc);
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fetch_queue (
    .clk   (clk),
    .reset (reset),
    .flush (bus.RedirectValid),
    .push  (push_c),
    .pop   (pop_c),
    .din   (entry_c),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.Address = pc;

  // Head fields are forced to zero while the queue is empty
  assign bus.OutValid       = ~empty;
  assign bus.OutPC          = empty ? '0 : head.pc;
  assign bus.OutInstruction = empty ? '0 : head.instr;
  assign bus.OutPCPlus4     = empty ? '0 : pc_inc(head.pc);

  a_count_bound : assert property (@(posedge clk) disable iff (reset)
    count <= CNT_W'(QUEUE_DEPTH));

endmodule
